// File: rtl/weighted_rr_arbiter.sv
// N-way weighted round-robin arbiter with registered one-hot grant and per-requester burst weights.
// Optional macro WRR_ARB_LOCK_EN adds a LOCK input that holds the current grantee past its weight.
module weighted_rr_arbiter #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          REQ,
  input  logic [N*WEIGHT_W-1:0] WEIGHT,
`ifdef WRR_ARB_LOCK_EN
  input  logic [N-1:0]          LOCK,
`endif
  output logic [N-1:0]          GNT,
  output logic [ID_W-1:0]       GNT_ID,
  output logic                  GNT_VALID
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [WEIGHT_W-1:0] r_credit;
  logic [N-1:0]        r_gnt;
  logic [ID_W-1:0]     r_gnt_id;
  logic                r_gnt_valid;

  state_t              w_state_nxt;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [WEIGHT_W-1:0] w_credit_nxt;
  logic [N-1:0]        w_gnt_nxt;
  logic [ID_W-1:0]     w_gnt_id_nxt;
  logic                w_gnt_valid_nxt;

  logic [WEIGHT_W-1:0] w_weight_g;
  logic [WEIGHT_W-1:0] w_lim;
  logic                w_req_g;
  logic                w_hold;
  logic                w_lock_hold;
  logic                w_found;
  logic [ID_W-1:0]     w_win;

  // Grantee's weight limit (w_eff-1, weight 0 acts as 1) and the hold/lock conditions.
  always_comb begin
    w_weight_g = WEIGHT[int'(r_gnt_id)*WEIGHT_W +: WEIGHT_W];
    if (w_weight_g == {WEIGHT_W{1'b0}}) begin
      w_lim = {WEIGHT_W{1'b0}};
    end else begin
      w_lim = w_weight_g - WEIGHT_W'(1);
    end
    w_req_g = REQ[r_gnt_id];
    // Compare before increment so credit stays within 2^WEIGHT_W-1.
    w_hold  = w_req_g && (r_credit < w_lim);
`ifdef WRR_ARB_LOCK_EN
    w_lock_hold = w_req_g && LOCK[r_gnt_id];
`else
    w_lock_hold = 1'b0;
`endif
  end

  // Rotating priority search starting at r_ptr, wrapping from N-1 back to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = {ID_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % N;
      if (!w_found && REQ[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end else begin
        w_win = w_win;
      end
    end
  end

  // Next-state and next-grant decision: hold, rotate, or fall idle.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_credit_nxt    = r_credit;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    case (r_state)
      ST_GRANT: begin
        if (w_lock_hold) begin
          w_credit_nxt = (r_credit < w_lim) ? (r_credit + WEIGHT_W'(1)) : w_lim;
        end else if (w_hold) begin
          w_credit_nxt = r_credit + WEIGHT_W'(1);
        end else if (w_found) begin
          w_gnt_nxt       = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_gnt_id_nxt    = w_win;
          w_gnt_valid_nxt = 1'b1;
          w_credit_nxt    = {WEIGHT_W{1'b0}};
          w_ptr_nxt       = ID_W'((int'(w_win) + 1) % N);
        end else begin
          w_gnt_nxt       = {N{1'b0}};
          w_gnt_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_found) begin
          w_gnt_nxt       = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_gnt_id_nxt    = w_win;
          w_gnt_valid_nxt = 1'b1;
          w_credit_nxt    = {WEIGHT_W{1'b0}};
          w_ptr_nxt       = ID_W'((int'(w_win) + 1) % N);
          w_state_nxt     = ST_GRANT;
        end else begin
          w_gnt_nxt       = {N{1'b0}};
          w_gnt_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = {N{1'b0}};
        w_gnt_valid_nxt = 1'b0;
        w_credit_nxt    = {WEIGHT_W{1'b0}};
      end
    endcase
  end

  // State, pointer, credit and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= {ID_W{1'b0}};
      r_credit    <= {WEIGHT_W{1'b0}};
      r_gnt       <= {N{1'b0}};
      r_gnt_id    <= {ID_W{1'b0}};
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_credit    <= w_credit_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
    end
  end

  assign GNT       = r_gnt;
  assign GNT_ID    = r_gnt_id;
  assign GNT_VALID = r_gnt_valid;

endmodule
